// File: rtl/ripple_pkg.sv
// ripple_pkg: shared types and helpers for the ripple counter capture stage.
package ripple_pkg;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        TRACK  = 2'd1,
        PEND   = 2'd2
    } state_e;

    localparam int RIPPLE_IN_W = 4;
    // run counter width covers STABLE_N up to 15
    localparam int RUN_W       = 4;
    // widest counter bus the delta helper handles
    localparam int DELTA_MAX_W = 16;

    // Forward distance from prev to cur on a w-bit wrapping counter.
    function automatic logic [DELTA_MAX_W-1:0] mod_delta(
        input logic [DELTA_MAX_W-1:0] cur,
        input logic [DELTA_MAX_W-1:0] prev,
        input int unsigned            w
    );
        logic [DELTA_MAX_W:0] mask;
        mask      = ((DELTA_MAX_W+1)'(1) << w) - (DELTA_MAX_W+1)'(1);
        mod_delta = (cur - prev) & mask[DELTA_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/ripple_sync_filter.sv
// ripple_sync_filter: two-flop resync of the ripple bus plus a run-length
// glitch filter. accept_o pulses on the edge where the candidate has been
// seen STABLE_N times in a row; cand_o is the candidate as of that edge.
module ripple_sync_filter
    import ripple_pkg::*;
#(
    parameter int IN_W     = RIPPLE_IN_W,
    parameter int STABLE_N = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] cnt_i,
    output logic            accept_o,
    output logic [IN_W-1:0] cand_o,
    output logic            full_o
);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_N);

    logic [IN_W-1:0]  s1_q, s2_q;
    logic [1:0]       prime_q;
    logic [IN_W-1:0]  cand_q, cand_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             accept;

    // Filter next state. Samples are ignored until s2 holds a real post-reset
    // value, so the zeroed sync flops are never mistaken for a counter value.
    always_comb begin
        cand_d = cand_q;
        run_d  = run_q;
        accept = 1'b0;
        if (prime_q[1]) begin
            if (s2_q != cand_q) begin
                cand_d = s2_q;
                run_d  = RUN_W'(1);
                accept = (RUN_MAX == RUN_W'(1));
            end else if (run_q != RUN_MAX) begin
                run_d  = run_q + RUN_W'(1);
                accept = (run_q == RUN_MAX - RUN_W'(1));
            end
        end
    end

    // Sync chain, priming flags and filter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            prime_q <= '0;
            cand_q  <= '0;
            run_q   <= '0;
        end else begin
            s1_q    <= cnt_i;
            s2_q    <= s1_q;
            prime_q <= {prime_q[0], 1'b1};
            cand_q  <= cand_d;
            run_q   <= run_d;
        end
    end

    assign accept_o = accept;
    assign cand_o   = cand_d;
    assign full_o   = (run_d == RUN_MAX);

endmodule

// File: rtl/ripple_sampler.sv
// ripple_sampler: captures the asynchronous ripple counter, extends it into a
// wide accumulator via modulo deltas and offers snapshots on a valid/ready port.
// Optional: RIPPLE_SAMPLER_OVERRUN_EN adds a sticky overrun flag for snapshots
// replaced before the consumer took them.
module ripple_sampler
    import ripple_pkg::*;
#(
    parameter int IN_W     = RIPPLE_IN_W,
    parameter int EXT_W    = 12,
    parameter int STABLE_N = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_W-1:0]       cnt_in,
    input  logic                  clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IN_W+EXT_W-1:0] out_count,
    output logic                  out_wrap,
    output logic                  stable
`ifdef RIPPLE_SAMPLER_OVERRUN_EN
    ,
    output logic                  overrun
`endif
);

    localparam int W = IN_W + EXT_W;

    logic            accept, full;
    logic [IN_W-1:0] cand;

    state_e          state_q;
    logic [IN_W-1:0] last_q, last_d;
    logic [W-1:0]    acc_q, acc_new;
    logic [IN_W-1:0] delta;
    logic            out_valid_q, out_wrap_q, stable_q;
    logic [W-1:0]    out_count_q;
    logic            has_base, new_snap, held;
`ifdef RIPPLE_SAMPLER_OVERRUN_EN
    logic            overrun_q;
`endif

    ripple_sync_filter #(
        .IN_W     (IN_W),
        .STABLE_N (STABLE_N)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .cnt_i    (cnt_in),
        .accept_o (accept),
        .cand_o   (cand),
        .full_o   (full)
    );

    assign delta    = IN_W'(mod_delta(DELTA_MAX_W'(cand), DELTA_MAX_W'(last_q), IN_W));
    assign acc_new  = acc_q + W'(delta);
    assign has_base = (state_q != SETTLE);
    // an acceptance equal to the current baseline carries no movement
    assign new_snap = accept && has_base && (cand != last_q);
    assign held     = (state_q == PEND) && !out_ready;

    // Baseline update; shared by the FSM and the registered stable flag.
    always_comb begin
        last_d = last_q;
        if (clr) begin
            if (has_base || accept) last_d = cand;
        end else if (accept && (!has_base || cand != last_q)) begin
            last_d = cand;
        end
    end

    // Capture FSM: baseline, accumulation and snapshot handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SETTLE;
            last_q      <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_wrap_q  <= 1'b0;
            stable_q    <= 1'b0;
`ifdef RIPPLE_SAMPLER_OVERRUN_EN
            overrun_q   <= 1'b0;
`endif
        end else begin
            last_q   <= last_d;
            stable_q <= full && (cand == last_d);
            if (clr) begin
                // a concurrent acceptance becomes the new baseline, no delta
                acc_q       <= '0;
                out_valid_q <= 1'b0;
                out_wrap_q  <= 1'b0;
                state_q     <= (has_base || accept) ? TRACK : SETTLE;
`ifdef RIPPLE_SAMPLER_OVERRUN_EN
                overrun_q   <= 1'b0;
`endif
            end else begin
                case (state_q)
                    SETTLE: begin
                        if (accept) state_q <= TRACK;
                    end
                    default: begin
                        if (new_snap) begin
                            // latest wins; wrap history kept if unconsumed
                            acc_q       <= acc_new;
                            out_count_q <= acc_new;
                            out_wrap_q  <= (cand < last_q) | (held & out_wrap_q);
                            out_valid_q <= 1'b1;
                            state_q     <= PEND;
`ifdef RIPPLE_SAMPLER_OVERRUN_EN
                            if (held) overrun_q <= 1'b1;
`endif
                        end else if (state_q == PEND && out_ready) begin
                            out_valid_q <= 1'b0;
                            state_q     <= TRACK;
                        end
                    end
                endcase
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_wrap  = out_wrap_q;
    assign stable    = stable_q;
`ifdef RIPPLE_SAMPLER_OVERRUN_EN
    assign overrun   = overrun_q;
`endif

endmodule

// File: doc/ripple_sampler.md
# ripple_sampler

Synchronous capture stage directly downstream of the 4-bit ripple counter. It resynchronises the counter's asynchronous `out` bus into the `clk` domain and rejects transition glitches by requiring consecutive identical samples. It extends the count to a wide accumulator using modulo deltas, then presents each new value through a valid/ready port to the logging/readout logic.

## Interface
- `IN_W`, 4, width of the ripple counter bus
- `EXT_W`, 12, extra accumulator bits above `IN_W`
- `STABLE_N`, 2, consecutive identical synchronised samples required to accept a value (range 1–15)

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cnt_in`  in  `IN_W`  ripple counter output, asynchronous to `clk`
- `clr`  in  1  synchronous clear of the accumulator and pending output
- `out_valid`  out  1  snapshot available
- `out_ready`  in  1  consumer accepts snapshot
- `out_count`  out  `IN_W+EXT_W`  extended count snapshot
- `out_wrap`  out  1  at least one `IN_W` wrap-around since the last accepted snapshot
- `stable`  out  1  the last synchronised sample equals the accepted value
- `overrun`  out  1  sticky; present only with `RIPPLE_SAMPLER_OVERRUN_EN`

## Operation
- Sync chain: `s1 <= cnt_in`, `s2 <= s1`. There is no combinational path from `cnt_in`.
- Filter: `cand` holds the last `s2` value and `run` counts consecutive cycles with `s2 == cand`. `run` saturates at `STABLE_N` and restarts at 1 when `s2 != cand`. A value is accepted on the edge where `run` reaches `STABLE_N`.
- FSM states:
  - SETTLE: no baseline yet. On the first acceptance, load `last <= cand`, emit no output, and go to TRACK.
  - TRACK: on an acceptance with `cand != last`:
    - `delta = (cand - last) mod 2^IN_W`
    - `acc <= acc + delta` (wraps modulo 2^(IN_W+EXT_W))
    - `last <= cand`
    - wrap event when `cand < last`
    - load the snapshot and go to PEND
  - TRACK: an acceptance with `cand == last` is ignored.
  - PEND: `out_valid=1`. Go back to TRACK when `out_ready` is high and no new acceptance occurs in the same cycle.
- Snapshot load: `out_count <= new acc`. `out_wrap <= wrap event`, ORed with the held `out_wrap` if the previous snapshot was not consumed.
- New acceptance while in PEND without `out_ready`: the newest snapshot replaces the held one (latest wins) and `out_wrap` accumulates.
- New acceptance in the same cycle as `out_ready`: the old snapshot is consumed, the new one loads, and `out_valid` stays 1.
- `clr`:
  - `acc <= 0`, `out_valid <= 0`, `out_wrap <= 0`
  - `last <= cand` if a baseline exists; otherwise the FSM stays in SETTLE
  - a concurrent acceptance is absorbed as the new baseline with no delta
- `rst` has priority over `clr`. Reset mid-operation discards everything and returns to SETTLE.

## Timing
- Reset values: `out_valid=0`, `out_count=0`, `out_wrap=0`, `stable=0`, `overrun=0`. Internally, `s1`, `s2`, `cand`, `run`, `last` and `acc` are all 0 and the FSM is in SETTLE.
- Latency: if `cnt_in` is steady before edge k, `out_valid` is high after edge k+1+`STABLE_N` (k+3 at default).
- `out_count` and `out_wrap` are registered and held constant while `out_valid=1 && out_ready=0`, unless a newer acceptance replaces them.
- `stable` is registered: `stable = (run == STABLE_N) && (cand == last)`.
- Throughput: at most one snapshot per cycle. Deltas larger than 2^IN_W−1 between acceptances are aliased; this is a system constraint, not detected.

## Configuration
- `RIPPLE_SAMPLER_OVERRUN_EN` defined: the `overrun` port exists. It is set on any snapshot replacement in PEND without `out_ready`, and cleared only by `rst` or `clr`.
- Not defined: the port and its logic are removed, and replacement is silent.

## Structure
- Shared package `ripple_pkg`:
  - FSM state enum `{SETTLE, TRACK, PEND}`
  - `RIPPLE_IN_W = 4` default constant
  - the modulo-delta function
- One sub-module `ripple_sync_filter` holds the sync chain, `cand`/`run` and the accept pulse. The top level holds the FSM, accumulator and handshake.

## Test plan
- Reset, `cnt_in=5` steady, `out_ready=1` → no `out_valid` (baseline only); `stable=1` after edge 4.
- `cnt_in` 5→9 steady, `out_ready=1` → `out_valid` for one cycle 3 edges after the change, `out_count=4`, `out_wrap=0`.
- `cnt_in` 14→2 → `out_count` increases by 4, `out_wrap=1`.
- `cnt_in` single-cycle glitch 9→0→9 → no acceptance, no `out_valid`, `acc` unchanged.
- `out_ready=0`, `cnt_in` 2→3, then 3→6 → one held snapshot updates to the `acc` +4 value. `overrun=1` with the macro; `out_ready` then drains in one cycle.
- `clr` while PEND, `cnt_in` steady at 6 → `out_valid=0` next cycle, `acc=0`. Then 6→7 → `out_count=1`. `rst` asserted together with `clr` → SETTLE, all outputs 0.
